// File: rtl/canvas_access_sequencer.sv
// Arbitrates the single canvas RAM port between cursor draws, a full-frame
// pixel stream toward the classifier, and a full-canvas clear.
module canvas_access_sequencer #(
   parameter int GRID_SIZE = 28,
   parameter int DEPTH     = GRID_SIZE * GRID_SIZE,
   parameter int ADDR_W    = 10
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              scan_start,
   input  logic              clear_start,
   input  logic              draw_req,
   input  logic [ADDR_W-1:0] draw_addr,
   input  logic              draw_data,
   output logic              draw_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic              ram_wdata,
   output logic              ram_re,
   input  logic              ram_rdata,
   output logic              pix_valid,
   output logic              pix_data,
   output logic [ADDR_W-1:0] pix_index,
   output logic              pix_last,
   input  logic              pix_ready,
   output logic              busy,
   output logic              scan_done,
   output logic              clear_done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_LAT  = 3'd2,
      S_OUT  = 3'd3,
      S_CLR  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] IDX_ZERO  = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              clear_pending_q, clear_pending_d;
   logic              pix_valid_q, pix_valid_d;
   logic              pix_data_q, pix_data_d;
   logic [ADDR_W-1:0] pix_index_q, pix_index_d;
   logic              pix_last_q, pix_last_d;
   logic              scan_done_q, scan_done_d;
   logic              clear_done_q, clear_done_d;
   logic              idx_last_s;
   logic              draw_in_range_s;

   assign idx_last_s      = (idx_q == LAST_IDX);
   assign draw_in_range_s = ({1'b0, draw_addr} < DEPTH_EXT);

   // State register and registered stream/pulse outputs
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         idx_q           <= IDX_ZERO;
         clear_pending_q <= 1'b0;
         pix_valid_q     <= 1'b0;
         pix_data_q      <= 1'b0;
         pix_index_q     <= IDX_ZERO;
         pix_last_q      <= 1'b0;
         scan_done_q     <= 1'b0;
         clear_done_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         clear_pending_q <= clear_pending_d;
         pix_valid_q     <= pix_valid_d;
         pix_data_q      <= pix_data_d;
         pix_index_q     <= pix_index_d;
         pix_last_q      <= pix_last_d;
         scan_done_q     <= scan_done_d;
         clear_done_q    <= clear_done_d;
      end
   end

   // Next-state, index and stream register logic
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      clear_pending_d = clear_pending_q | clear_start;
      pix_valid_d     = pix_valid_q;
      pix_data_d      = pix_data_q;
      pix_index_d     = pix_index_q;
      pix_last_d      = pix_last_q;
      scan_done_d     = 1'b0;
      clear_done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            idx_d = IDX_ZERO;
            // A same-cycle clear_start stays pending so it runs after the scan
            if (scan_start) begin
               state_d = S_RD;
            end else if (clear_start | clear_pending_q) begin
               state_d         = S_CLR;
               clear_pending_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            state_d = S_LAT;
         end
         S_LAT: begin
            pix_data_d  = ram_rdata;
            pix_index_d = idx_q;
            pix_last_d  = idx_last_s;
            pix_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (pix_ready) begin
               pix_valid_d = 1'b0;
               if (idx_last_s) begin
                  scan_done_d = 1'b1;
                  idx_d       = IDX_ZERO;
                  if (clear_pending_d) begin
                     state_d         = S_CLR;
                     clear_pending_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = S_RD;
               end
            end else begin
               state_d = S_OUT;
            end
         end
         S_CLR: begin
            if (idx_last_s) begin
               clear_done_d = 1'b1;
               idx_d        = IDX_ZERO;
               state_d      = S_IDLE;
            end else begin
               idx_d   = idx_q + IDX_ONE;
               state_d = S_CLR;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = IDX_ZERO;
         end
      endcase
   end

   // RAM port steering; draws are only served while idle
   always_comb begin
      ram_addr   = idx_q;
      ram_we     = 1'b0;
      ram_wdata  = 1'b0;
      ram_re     = 1'b0;
      draw_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            ram_addr   = draw_addr;
            draw_ready = ~reset;
            ram_we     = draw_req & draw_in_range_s & ~reset;
            if (draw_req & ~reset) begin
               ram_wdata = draw_data;
            end else begin
               ram_wdata = 1'b0;
            end
         end
         S_RD: begin
            ram_re = 1'b1;
         end
         S_CLR: begin
            ram_we = 1'b1;
         end
         default: begin
            ram_re = 1'b0;
         end
      endcase
   end

   assign pix_valid  = pix_valid_q;
   assign pix_data   = pix_data_q;
   assign pix_index  = pix_index_q;
   assign pix_last   = pix_last_q;
   assign scan_done  = scan_done_q;
   assign clear_done = clear_done_q;
   assign busy       = (state_q != S_IDLE) | clear_pending_q;

endmodule

// File: tb/tb_canvas_access_sequencer.sv
// Bench for canvas_access_sequencer: a RAM model plus a golden canvas image
// that predicts every streamed pixel, draw acceptance and clear behaviour.
module tb_canvas_access_sequencer;

   localparam int DEPTH = 784;
   localparam int LIMIT = 9000;

   logic       CLOCK_50 = 1'b0;
   logic       reset, scan_start, clear_start, draw_req, draw_data, ram_rdata, pix_ready;
   logic [9:0] draw_addr, ram_addr, pix_index;
   logic       draw_ready, ram_we, ram_wdata, ram_re, pix_valid, pix_data, pix_last;
   logic       busy, scan_done, clear_done;

   logic mem [0:1023];
   bit   golden [0:1023];
   bit   exp_img [0:1023];
   int   total = 0, bad = 0;
   int   beats, sd_cnt, cd_cnt, rw_err, dr_err, cl_err;

   typedef struct {
      logic       req;
      logic [9:0] addr;
      logic       data;
      logic       exp_ready;
      logic       exp_we;
   } vec_t;
   vec_t vecs [9];

   canvas_access_sequencer dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .scan_start(scan_start), .clear_start(clear_start),
      .draw_req(draw_req), .draw_addr(draw_addr), .draw_data(draw_data), .draw_ready(draw_ready),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_re(ram_re),
      .ram_rdata(ram_rdata), .pix_valid(pix_valid), .pix_data(pix_data), .pix_index(pix_index),
      .pix_last(pix_last), .pix_ready(pix_ready), .busy(busy), .scan_done(scan_done),
      .clear_done(clear_done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Synchronous single-port canvas RAM with one-cycle read latency
   always @(posedge CLOCK_50) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #2;
   endtask

   // Called once per negedge while anything is running
   task automatic sample();
      if (ram_re && ram_we) rw_err++;
      if (scan_done) sd_cnt++;
      if (clear_done) cd_cnt++;
      if (pix_valid && pix_ready) begin
         if (beats < DEPTH) begin
            check("beat_index", 32'(pix_index), 32'(beats));
            check("beat_data", 32'(pix_data), 32'(exp_img[beats]));
            check("beat_last", 32'(pix_last), 32'(beats == DEPTH - 1));
         end else begin
            check("beat_overrun", 32'(beats), 32'(DEPTH - 1));
         end
         beats++;
      end
   endtask

   task automatic prep_scan();
      for (int i = 0; i < 1024; i++) exp_img[i] = golden[i];
      beats = 0; sd_cnt = 0; cd_cnt = 0; dr_err = 0; cl_err = 0;
   endtask

   task automatic start_scan(input bit with_clear);
      prep_scan();
      scan_start = 1'b1; clear_start = with_clear;
      step();
      scan_start = 1'b0; clear_start = 1'b0;
   endtask

   // Ends at the negedge where scan_done is visible; cyc counts from RD entry
   task automatic wait_scan(input bit rnd, input int clr_at, input int rescan_at, output int cyc);
      @(negedge CLOCK_50); sample();
      cyc = 0;
      while (!scan_done && cyc < LIMIT) begin
         if (draw_ready) dr_err++;
         @(posedge CLOCK_50); #2;
         cyc++;
         pix_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         scan_start  = (cyc == rescan_at);
         clear_start = (cyc == clr_at);
         @(negedge CLOCK_50); sample();
      end
      scan_start = 1'b0; clear_start = 1'b0; pix_ready = 1'b1;
      check("scan_finished", 32'(scan_done), 32'd1);
   endtask

   // Starts at a negedge where the first clear cycle is visible
   task automatic wait_clear(output int cyc);
      cyc = 0;
      while (!clear_done && cyc < LIMIT) begin
         if (!(ram_we && !ram_wdata && !ram_re && ram_addr == cyc[9:0] && busy)) cl_err++;
         @(negedge CLOCK_50); sample();
         cyc++;
      end
      check("clear_cycles", 32'(cyc), 32'(DEPTH));
      check("clear_writes", 32'(cl_err), 32'd0);
      for (int i = 0; i < 1024; i++) golden[i] = 1'b0;
   endtask

   task automatic tick();
      @(negedge CLOCK_50); sample();
   endtask

   initial begin
      int   cyc, cc, n, clr_at, rescan_at;
      bit   with_clear;
      logic held;

      vecs[0] = '{1'b1, 10'd406,  1'b1, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 10'd800,  1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 10'd783,  1'b1, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 10'd0,    1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 10'd784,  1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 10'd10,   1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 10'd1023, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 10'd100,  1'b0, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 10'd5,    1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 1024; i++) golden[i] = 1'b0;
      rw_err = 0; beats = 0; sd_cnt = 0; cd_cnt = 0;

      reset = 1'b1; scan_start = 1'b0; clear_start = 1'b0; draw_req = 1'b0;
      draw_addr = 10'd77; draw_data = 1'b0; pix_ready = 1'b1;
      step(); step();
      check("rst_draw_ready", 32'(draw_ready), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_re", 32'(ram_re), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'({scan_done, clear_done}), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd77);
      reset = 1'b0;
      step();

      // Clear from idle gives the RAM a known all-zero starting image
      clear_start = 1'b1; step(); clear_start = 1'b0;
      cd_cnt = 0; cl_err = 0;
      tick();
      wait_clear(cc);
      tick();
      check("idle_clear_done_once", 32'(cd_cnt), 32'd1);
      check("idle_clear_busy_end", 32'(busy), 32'd0);

      for (int i = 0; i < 9; i++) begin
         draw_req = vecs[i].req; draw_addr = vecs[i].addr; draw_data = vecs[i].data;
         #1;
         check("vec_draw_ready", 32'(draw_ready), 32'(vecs[i].exp_ready));
         check("vec_ram_we", 32'(ram_we), 32'(vecs[i].exp_we));
         if (vecs[i].req) check("vec_ram_addr", 32'(ram_addr), 32'(vecs[i].addr));
         step();
         if (vecs[i].exp_we) golden[vecs[i].addr] = vecs[i].data;
      end
      draw_req = 1'b0;

      // Full scan at full rate
      start_scan(1'b0);
      wait_scan(1'b0, -1, -1, cyc);
      check("scan_cycles", 32'(cyc), 32'd2352);
      tick();
      check("scan_beats", 32'(beats), 32'(DEPTH));
      check("scan_done_once", 32'(sd_cnt), 32'd1);
      check("scan_draw_ready_low", 32'(dr_err), 32'd0);
      check("scan_busy_end", 32'(busy), 32'd0);

      // Backpressure held for 10 cycles on pixel 5
      prep_scan();
      scan_start = 1'b1; pix_ready = 1'b0; step(); scan_start = 1'b0;
      @(negedge CLOCK_50); sample();
      for (int k = 0; k < 7; k++) begin
         n = 0;
         while (!pix_valid && n < 10) begin @(negedge CLOCK_50); sample(); n++; end
         check("bp_valid_wait", 32'(pix_valid), 32'd1);
         if (k == 5) begin
            held = pix_data; n = 0;
            repeat (10) begin
               @(negedge CLOCK_50); sample();
               if (!pix_valid || pix_index != 10'd5 || pix_data != held || ram_re) n++;
            end
            check("bp_hold_stable", 32'(n), 32'd0);
            check("bp_hold_index", 32'(pix_index), 32'd5);
         end
         if (k == 6) check("bp_next_index", 32'(pix_index), 32'd6);
         @(posedge CLOCK_50); #2; pix_ready = 1'b1;
         @(negedge CLOCK_50); sample();
         @(posedge CLOCK_50); #2; pix_ready = 1'b0;
      end
      pix_ready = 1'b1;
      wait_scan(1'b0, -1, -1, cyc);
      tick();
      check("bp_beats", 32'(beats), 32'(DEPTH));
      check("bp_done_once", 32'(sd_cnt), 32'd1);

      // Draw, scan and clear requested together
      draw_req = 1'b1; draw_addr = 10'd0; draw_data = 1'b0; step();
      golden[0] = 1'b0;
      draw_data = 1'b1; scan_start = 1'b1; clear_start = 1'b1;
      #1;
      check("sim_draw_ready", 32'(draw_ready), 32'd1);
      check("sim_ram_we", 32'(ram_we), 32'd1);
      golden[0] = 1'b1;
      prep_scan();
      step();
      draw_req = 1'b0; scan_start = 1'b0; clear_start = 1'b0;
      wait_scan(1'b0, -1, -1, cyc);
      check("sim_scan_cycles", 32'(cyc), 32'd2352);
      wait_clear(cc);
      tick();
      check("sim_scan_done_once", 32'(sd_cnt), 32'd1);
      check("sim_clear_done_once", 32'(cd_cnt), 32'd1);
      check("sim_busy_end", 32'(busy), 32'd0);

      start_scan(1'b0);
      wait_scan(1'b0, -1, -1, cyc);
      tick();
      check("rescan_beats", 32'(beats), 32'(DEPTH));

      // Reset in the middle of a scan with a clear pending
      golden[300] = 1'b1; golden[0] = 1'b1;
      draw_req = 1'b1; draw_addr = 10'd300; draw_data = 1'b1; step();
      draw_addr = 10'd0; step(); draw_req = 1'b0;
      start_scan(1'b0);
      @(negedge CLOCK_50); sample();
      n = 0;
      while (!(pix_valid && pix_index == 10'd300) && n < LIMIT) begin
         @(posedge CLOCK_50); #2;
         clear_start = (n == 10);
         n++;
         @(negedge CLOCK_50); sample();
      end
      clear_start = 1'b0;
      check("mid_reached_300", 32'(pix_index), 32'd300);
      reset = 1'b1;
      #1;
      check("mid_rst_pix", 32'({pix_valid, pix_data, pix_last}), 32'd0);
      check("mid_rst_index", 32'(pix_index), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ram", 32'({ram_re, ram_we, draw_ready}), 32'd0);
      step();
      reset = 1'b0;
      step(); step();
      check("mid_post_busy", 32'(busy), 32'd0);
      check("mid_post_idle", 32'(draw_ready), 32'd1);
      start_scan(1'b0);
      wait_scan(1'b0, -1, -1, cyc);
      tick();
      check("mid_rescan_beats", 32'(beats), 32'(DEPTH));
      check("mid_no_clear", 32'(cd_cnt), 32'd0);

      // Randomized draws, stalls, stray starts and deferred clears
      for (int it = 0; it < 3; it++) begin
         for (int d = 0; d < 30; d++) begin
            draw_req = 1'b1;
            draw_addr = 10'($urandom_range(0, 1023));
            draw_data = 1'($urandom_range(0, 1));
            #1;
            check("rnd_draw_ready", 32'(draw_ready), 32'd1);
            check("rnd_ram_we", 32'(ram_we), 32'(draw_addr < 10'd784));
            step();
            if (draw_addr < 10'd784) golden[draw_addr] = draw_data;
         end
         draw_req = 1'b0;
         with_clear = ($urandom_range(0, 2) == 0);
         clr_at     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 1500)) : -1;
         rescan_at  = int'($urandom_range(1, 1500));
         start_scan(with_clear);
         wait_scan(1'b1, clr_at, rescan_at, cyc);
         if (with_clear || clr_at > 0) wait_clear(cc);
         tick();
         check("rnd_beats", 32'(beats), 32'(DEPTH));
         check("rnd_scan_done_once", 32'(sd_cnt), 32'd1);
         check("rnd_clear_done", 32'(cd_cnt), 32'(with_clear || clr_at > 0));
         check("rnd_busy_end", 32'(busy), 32'd0);
      end

      check("re_we_exclusive", 32'(rw_err), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/canvas_access_sequencer.md
Name: canvas_access_sequencer

Overview:
Owns the single read/write port of the 28x28 1-bit canvas RAM and schedules three users onto it: cursor draw writes, a full-frame scan that streams all pixels to the network input, and a full-canvas clear. It sits between the drawing/cursor logic and the classifier front end. The display path reads through a separate RAM read port and is outside this block.

Parameters:
GRID_SIZE, 28, canvas edge length in cells
DEPTH, GRID_SIZE*GRID_SIZE (784), number of canvas cells
ADDR_W, 10, address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
scan_start  in  1  one-cycle request to stream the whole canvas
clear_start  in  1  one-cycle request to zero the whole canvas
draw_req  in  1  draw write request, held until draw_ready
draw_addr  in  ADDR_W  draw cell address (y*GRID_SIZE+x)
draw_data  in  1  value to write
draw_ready  out  1  draw request accepted this cycle
ram_addr  out  ADDR_W  canvas RAM address
ram_we  out  1  canvas RAM write enable
ram_wdata  out  1  canvas RAM write data
ram_re  out  1  canvas RAM read enable
ram_rdata  in  1  RAM read data, valid one cycle after ram_re
pix_valid  out  1  stream data valid
pix_data  out  1  streamed pixel
pix_index  out  ADDR_W  address of streamed pixel
pix_last  out  1  high with pixel DEPTH-1
pix_ready  in  1  downstream accept
busy  out  1  scan or clear in progress, or clear pending
scan_done  out  1  one-cycle pulse after last pixel accepted
clear_done  out  1  one-cycle pulse after last zero written

Behaviour:
- Reset (async, any state): state IDLE. idx=0. clear_pending=0. All outputs 0, except ram_addr=draw_addr passthrough as below. RAM contents are untouched.
- States: IDLE, RD, LAT, OUT, CLR.
- IDLE:
  - draw_ready=1 combinationally. When draw_req=1: ram_addr=draw_addr, ram_wdata=draw_data, ram_we=1 if draw_addr<DEPTH.
  - A draw with draw_addr>=DEPTH is consumed (draw_ready=1) with no write.
  - scan_start takes precedence. Next state is RD with idx=0.
  - Otherwise, if clear_start or clear_pending: next state is CLR with idx=0, and clear_pending is cleared.
  - A draw accepted in the same cycle as a start completes before the first scan read or clear write.
- RD: ram_addr=idx, ram_re=1. Next state LAT.
- LAT: register pix_data<=ram_rdata, pix_index<=idx, pix_last<=(idx==DEPTH-1), pix_valid<=1. Next state OUT.
- OUT:
  - pix_valid=1. pix_data, pix_index and pix_last are held stable until pix_ready.
  - On pix_ready: pix_valid<=0. If idx==DEPTH-1, pulse scan_done for one cycle, then go to CLR if clear_pending else IDLE. Otherwise idx<=idx+1 and return to RD.
  - Minimum rate is 3 cycles per pixel. Full-scan minimum is 2352 cycles from the RD entry.
- CLR: ram_addr=idx, ram_we=1, ram_wdata=0, idx++ each cycle. After the write at DEPTH-1, pulse clear_done and return to IDLE. Duration is exactly DEPTH cycles.
- Outside IDLE: draw_ready=0, and the requester holds draw_req/addr/data.
- scan_start while not IDLE is ignored. Two scan_starts in a row during a scan do not queue.
- clear_start while not IDLE sets clear_pending. Multiple requests collapse into one.
- clear_start in the same IDLE cycle as scan_start sets clear_pending; the clear runs directly after the scan.
- busy = (state!=IDLE) | clear_pending.
- idx is ADDR_W bits and never exceeds DEPTH-1; no wrap-around occurs.
- ram_re and ram_we are never high in the same cycle.

Test Plan:
- Draw in IDLE: draw_req=1, addr=406, data=1 → same-cycle draw_ready=1, ram_we=1, ram_addr=406. A later scan gives pix_data=1 at pix_index=406.
- Full scan, pix_ready always 1, RAM cells 0 and 783 set to 1 → 784 beats, indices 0..783 in order. pix_last only at 783. scan_done pulses once, 2352 cycles after RD entry. draw_ready=0 throughout.
- Backpressure: hold pix_ready=0 for 10 cycles at index 5 → pix_valid stays 1 and pix_data/pix_index stay frozen. No RAM read is issued. Index 6 follows the release.
- Simultaneous events: scan_start, clear_start and draw_req (addr 0, data 1) in one IDLE cycle → draw written first. Scan streams index 0 as 1, then CLR runs 784 cycles. clear_done pulses, and a rescan reads all zeros.
- Draw with draw_addr=800 → draw_ready=1, ram_we=0.
- Reset mid-scan at index 300 → all outputs 0 immediately, state IDLE, clear_pending=0. A fresh scan restarts at index 0.
